// File: rtl/gol_gen_engine.sv
`default_nettype none
// ============================================================================
//  Module   : gol_gen_engine
//  Purpose  : Streaming next-generation engine for a WIDTH x HEIGHT
//             Game-of-Life grid. It accepts one row of the current generation
//             per handshake and emits one row of the next generation per
//             handshake. The birth/survive rule set can be changed at run
//             time, and the grid edges can be dead or toroidal.
//  Ports    : i_clk, i_rst        clock, synchronous active-high reset
//             i_wrap              1 = toroidal edges, 0 = dead border
//             i_birth/i_survive   rule masks indexed by neighbour count
//             i_row_valid/o_row_ready/i_row               input row stream
//             o_out_valid/i_out_ready/o_out_row/idx/last  output row stream
//             o_gen_done          one-cycle pulse after final output handshake
//             o_busy              generation in progress
//  Revision : 1.0  initial release
// ============================================================================
module gol_gen_engine #(
    parameter int WIDTH  = 16,
    parameter int HEIGHT = 16,
    parameter int IDX_W  = $clog2(HEIGHT)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wrap,
    input  logic [8:0]       i_birth,
    input  logic [8:0]       i_survive,
    input  logic             i_row_valid,
    output logic             o_row_ready,
    input  logic [WIDTH-1:0] i_row,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_row,
    output logic [IDX_W-1:0] o_out_idx,
    output logic             o_out_last,
    output logic             o_gen_done,
    output logic             o_busy
);

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(HEIGHT - 1);
    localparam logic [IDX_W-1:0] c_ONE      = IDX_W'(1);

    typedef enum logic [0:0] {
        ST_STREAM = 1'b0,
        ST_FLUSH  = 1'b1
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_cnt;        // rows accepted so far this generation
    logic [WIDTH-1:0] r_above;      // row r-2 at acceptance of row r
    logic [WIDTH-1:0] r_cur;        // row r-1 at acceptance of row r
    logic [WIDTH-1:0] r_row0;       // saved rows 0 and 1: needed last in wrap mode
    logic [WIDTH-1:0] r_row1;
    logic             r_wrap;
    logic [8:0]       r_birth;
    logic [8:0]       r_survive;
    logic             r_fl_phase;   // 0: row HEIGHT-1 still to load, 1: wrap row 0

    logic             w_in_xfer;
    logic             w_out_xfer;
    logic [WIDTH-1:0] w_stream_row;
    logic [WIDTH-1:0] w_flush_row;
    logic [WIDTH-1:0] w_wrap_row0;

    // Applies the rule to one row given the rows above and below it.
    function automatic logic [WIDTH-1:0] next_row(
        input logic [WIDTH-1:0] up,
        input logic [WIDTH-1:0] mid,
        input logic [WIDTH-1:0] dn,
        input logic             wrap,
        input logic [8:0]       birth,
        input logic [8:0]       survive
    );
        logic [WIDTH-1:0] res;
        logic [3:0]       n;
        int               lc;
        int               rc;
        res = '0;
        for (int c = 0; c < WIDTH; c++) begin
            lc = (c == 0)         ? WIDTH - 1 : c - 1;
            rc = (c == WIDTH - 1) ? 0         : c + 1;
            n  = {3'b000, up[c]} + {3'b000, dn[c]};
            if (wrap || c != 0)
                n = n + {3'b000, up[lc]} + {3'b000, mid[lc]} + {3'b000, dn[lc]};
            if (wrap || c != WIDTH - 1)
                n = n + {3'b000, up[rc]} + {3'b000, mid[rc]} + {3'b000, dn[rc]};
            res[c] = mid[c] ? survive[n] : birth[n];
        end
        return res;
    endfunction

    assign w_in_xfer   = i_row_valid & o_row_ready;
    assign w_out_xfer  = o_out_valid & i_out_ready;
    assign o_row_ready = (r_state == ST_STREAM) & (~o_out_valid | i_out_ready);

    // Streaming row: incoming row is the "below" neighbour of row r-1.
    assign w_stream_row = next_row(r_above, r_cur, i_row, r_wrap, r_birth, r_survive);
    // Last row: below neighbour is row 0 in wrap mode, dead otherwise.
    assign w_flush_row  = next_row(r_above, r_cur, r_wrap ? r_row0 : '0,
                                   r_wrap, r_birth, r_survive);
    // Wrap-mode row 0 is deferred until row HEIGHT-1 is known.
    assign w_wrap_row0  = next_row(r_cur, r_row0, r_row1, 1'b1, r_birth, r_survive);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_STREAM;
            r_cnt       <= '0;
            r_above     <= '0;
            r_cur       <= '0;
            r_row0      <= '0;
            r_row1      <= '0;
            r_wrap      <= 1'b0;
            r_birth     <= '0;
            r_survive   <= '0;
            r_fl_phase  <= 1'b0;
            o_out_valid <= 1'b0;
            o_out_row   <= '0;
            o_out_idx   <= '0;
            o_out_last  <= 1'b0;
            o_gen_done  <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            o_gen_done <= 1'b0;
            case (r_state)
                ST_STREAM: begin
                    if (w_in_xfer) begin
                        // Row 0 has no row above in dead mode; start from zero.
                        r_above <= (r_cnt == '0) ? '0 : r_cur;
                        r_cur   <= i_row;
                        if (r_cnt == '0) begin
                            r_wrap    <= i_wrap;
                            r_birth   <= i_birth;
                            r_survive <= i_survive;
                            r_row0    <= i_row;
                            o_busy    <= 1'b1;
                        end
                        if (r_cnt == c_ONE)
                            r_row1 <= i_row;
                        if (r_cnt == '0 || (r_cnt == c_ONE && r_wrap)) begin
                            if (w_out_xfer)
                                o_out_valid <= 1'b0;
                        end else begin
                            o_out_valid <= 1'b1;
                            o_out_row   <= w_stream_row;
                            o_out_idx   <= r_cnt - c_ONE;
                            o_out_last  <= 1'b0;
                        end
                        if (r_cnt == c_LAST_IDX) begin
                            r_state    <= ST_FLUSH;
                            r_fl_phase <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + c_ONE;
                        end
                    end else if (w_out_xfer) begin
                        o_out_valid <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    if (w_out_xfer) begin
                        if (o_out_last) begin
                            o_out_valid <= 1'b0;
                            o_out_last  <= 1'b0;
                            o_gen_done  <= 1'b1;
                            o_busy      <= 1'b0;
                            r_cnt       <= '0;
                            r_state     <= ST_STREAM;
                        end else if (!r_fl_phase) begin
                            o_out_row  <= w_flush_row;
                            o_out_idx  <= c_LAST_IDX;
                            o_out_last <= ~r_wrap;
                            r_fl_phase <= 1'b1;
                        end else begin
                            o_out_row  <= w_wrap_row0;
                            o_out_idx  <= '0;
                            o_out_last <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_STREAM;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gol_gen_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gol_gen_engine
//  Purpose  : Self-checking bench for gol_gen_engine on a 5x5 grid. Expected
//             rows come from a direct neighbour-counting model of the grid.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gol_gen_engine;

    localparam int W  = 5;
    localparam int H  = 5;
    localparam int IW = $clog2(H);
    localparam int NBUF = 4 * H;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b0;
    logic          i_wrap = 1'b0;
    logic [8:0]    i_birth = '0;
    logic [8:0]    i_survive = '0;
    logic          i_row_valid = 1'b0;
    logic          o_row_ready;
    logic [W-1:0]  i_row = '0;
    logic          o_out_valid;
    logic          i_out_ready = 1'b0;
    logic [W-1:0]  o_out_row;
    logic [IW-1:0] o_out_idx;
    logic          o_out_last;
    logic          o_gen_done;
    logic          o_busy;

    int checks = 0;
    int errors = 0;

    // Stimulus rows, model grid, and captured output rows.
    logic [W-1:0]  in_rows [0:NBUF-1];
    logic [W-1:0]  mg      [0:H-1];
    logic [W-1:0]  got_row [0:NBUF-1];
    logic [IW-1:0] got_idx [0:NBUF-1];
    logic          got_last[0:NBUF-1];
    int n_got, n_done, proto_err, n_stall, g_cycles;
    bit timeout;

    gol_gen_engine #(.WIDTH(W), .HEIGHT(H)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_wrap     (i_wrap),
        .i_birth    (i_birth),
        .i_survive  (i_survive),
        .i_row_valid(i_row_valid),
        .o_row_ready(o_row_ready),
        .i_row      (i_row),
        .o_out_valid(o_out_valid),
        .i_out_ready(i_out_ready),
        .o_out_row  (o_out_row),
        .o_out_idx  (o_out_idx),
        .o_out_last (o_out_last),
        .o_gen_done (o_gen_done),
        .o_busy     (o_busy)
    );

    always #5 i_clk = ~i_clk;

    // Reference: count the 8 neighbours of every cell of row r in grid mg.
    function automatic logic [W-1:0] model_row(int r, bit wrap, logic [8:0] b, logic [8:0] s);
        logic [W-1:0] res;
        int n, rr, cc;
        res = '0;
        for (int c = 0; c < W; c++) begin
            n = 0;
            for (int dr = -1; dr <= 1; dr++) begin
                for (int dc = -1; dc <= 1; dc++) begin
                    if (dr != 0 || dc != 0) begin
                        rr = r + dr;
                        cc = c + dc;
                        if (wrap) begin
                            rr = (rr + H) % H;
                            cc = (cc + W) % W;
                            n += int'(mg[rr][cc]);
                        end else if (rr >= 0 && rr < H && cc >= 0 && cc < W) begin
                            n += int'(mg[rr][cc]);
                        end
                    end
                end
            end
            res[c] = mg[r][c] ? s[n] : b[n];
        end
        return res;
    endfunction

    // Drives n_gens*H rows from in_rows and records every output handshake.
    // rmode: 0 ready always, 1 random ready, 2 ready low for cycles 4..7.
    // vmode: 0 valid always, 1 random valid. toggle: invert rules after row 0.
    task automatic run_gen(input int n_gens, input bit wrap, input logic [8:0] b,
                           input logic [8:0] s, input int rmode, input int vmode,
                           input bit toggle);
        int k, cyc, total;
        bit acc, pend;
        logic [W-1:0] p_row;
        logic [IW-1:0] p_idx;
        logic p_last;
        total = n_gens * H;
        k = 0; cyc = 0; pend = 0;
        n_got = 0; n_done = 0; proto_err = 0; n_stall = 0; timeout = 0;
        p_row = '0; p_idx = '0; p_last = 1'b0;
        for (int i = 0; i < NBUF; i++) begin
            got_row[i] = '1; got_idx[i] = '1; got_last[i] = 1'b1;
        end
        i_wrap = wrap; i_birth = b; i_survive = s;
        i_row_valid = (vmode == 0) || ($urandom % 3 != 0);
        i_row = in_rows[0];
        i_out_ready = (rmode == 1) ? ($urandom % 3 != 0) : 1'b1;
        while (n_done < n_gens && cyc < 300) begin
            @(negedge i_clk);
            if (pend && (o_out_row !== p_row || o_out_idx !== p_idx ||
                         o_out_last !== p_last || o_out_valid !== 1'b1))
                proto_err++;
            if (o_out_valid && !i_out_ready) begin
                n_stall++;
                if (o_row_ready) proto_err++;
                pend = 1; p_row = o_out_row; p_idx = o_out_idx; p_last = o_out_last;
            end else begin
                pend = 0;
            end
            acc = i_row_valid && o_row_ready;
            if (o_out_valid && i_out_ready && n_got < NBUF) begin
                got_row[n_got] = o_out_row;
                got_idx[n_got] = o_out_idx;
                got_last[n_got] = o_out_last;
                n_got++;
            end
            if (o_gen_done) begin
                n_done++;
                if (o_busy || o_out_valid) proto_err++;
            end
            @(posedge i_clk);
            #1;
            cyc++;
            if (acc) begin
                k++;
                if (toggle && (k % H == 1)) begin
                    i_birth = ~b; i_survive = ~s; i_wrap = ~wrap;
                end else if (k % H == 0) begin
                    i_birth = b; i_survive = s; i_wrap = wrap;
                end
            end
            if (!(i_row_valid && !acc)) begin
                i_row_valid = (k < total) && ((vmode == 0) || ($urandom % 3 != 0));
                i_row = (k < total) ? in_rows[k] : W'($urandom);
            end
            case (rmode)
                1:       i_out_ready = ($urandom % 3 != 0);
                2:       i_out_ready = !(cyc >= 4 && cyc < 8);
                default: i_out_ready = 1'b1;
            endcase
        end
        timeout = (n_done < n_gens);
        g_cycles = cyc;
        i_row_valid = 1'b0;
        i_birth = b; i_survive = s; i_wrap = wrap;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        i_row_valid = 1'b0;
        i_out_ready = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        checks++;
        if (o_row_ready !== 1'b1 || o_out_valid !== 1'b0 || o_busy !== 1'b0 ||
            o_gen_done !== 1'b0 || o_out_last !== 1'b0 || o_out_row !== '0 || o_out_idx !== '0) begin
            errors++;
            $display("FAIL reset: got ready %b valid %b busy %b done %b last %b row %b idx %0d, want 1 0 0 0 0 0 0",
                     o_row_ready, o_out_valid, o_busy, o_gen_done, o_out_last, o_out_row, o_out_idx);
        end
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
    endtask

    task automatic load_blinker();
        in_rows[0] = 5'b00000; in_rows[1] = 5'b00100; in_rows[2] = 5'b00100;
        in_rows[3] = 5'b00100; in_rows[4] = 5'b00000;
    endtask

    task automatic test_blinker(input string tag);
        logic [W-1:0] exp_rows [0:H-1];
        exp_rows[0] = 5'b00000; exp_rows[1] = 5'b00000; exp_rows[2] = 5'b01110;
        exp_rows[3] = 5'b00000; exp_rows[4] = 5'b00000;
        load_blinker();
        run_gen(1, 1'b0, 9'h008, 9'h00C, 0, 0, 1'b0);
        checks++;
        if (n_got !== H || n_done !== 1 || timeout || proto_err !== 0) begin
            errors++;
            $display("FAIL %s count: got rows %0d done %0d perr %0d, want %0d 1 0", tag, n_got, n_done, proto_err, H);
        end
        for (int p = 0; p < H; p++) begin
            checks++;
            if (got_row[p] !== exp_rows[p] || got_idx[p] !== IW'(p) || got_last[p] !== (p == H - 1)) begin
                errors++;
                $display("FAIL %s row%0d: got idx %0d row %b last %b, want idx %0d row %b last %b",
                         tag, p, got_idx[p], got_row[p], got_last[p], p, exp_rows[p], p == H - 1);
            end
        end
    endtask

    task automatic test_full_row();
        logic [W-1:0] exp_row;
        logic [IW-1:0] exp_idx;
        for (int m = 0; m < 2; m++) begin
            for (int r = 0; r < H; r++) in_rows[r] = (r == 2) ? 5'b11111 : 5'b00000;
            run_gen(1, m[0], 9'h008, 9'h00C, 0, 0, 1'b0);
            checks++;
            if (n_got !== H || timeout) begin
                errors++;
                $display("FAIL full_row wrap=%0d count: got %0d, want %0d", m, n_got, H);
            end
            for (int p = 0; p < H; p++) begin
                exp_idx = (m == 1) ? IW'((p + 1) % H) : IW'(p);
                if (exp_idx >= 1 && exp_idx <= 3) exp_row = (m == 1) ? 5'b11111 : 5'b01110;
                else exp_row = 5'b00000;
                checks++;
                if (got_row[p] !== exp_row || got_idx[p] !== exp_idx || got_last[p] !== (p == H - 1)) begin
                    errors++;
                    $display("FAIL full_row wrap=%0d pos%0d: got idx %0d row %b last %b, want idx %0d row %b last %b",
                             m, p, got_idx[p], got_row[p], got_last[p], exp_idx, exp_row, p == H - 1);
                end
            end
        end
    endtask

    task automatic test_random();
        bit wrap;
        logic [8:0] b, s;
        logic [IW-1:0] exp_idx;
        logic [W-1:0] exp_row;
        for (int g = 0; g < 8; g++) begin
            for (int r = 0; r < H; r++) begin
                mg[r] = W'($urandom);
                in_rows[r] = mg[r];
            end
            wrap = bit'($urandom % 2);
            b = (g < 3) ? 9'h008 : 9'($urandom);
            s = (g < 3) ? 9'h00C : 9'($urandom);
            run_gen(1, wrap, b, s, 1, 1, 1'b0);
            checks++;
            if (n_got !== H || n_done !== 1 || timeout || proto_err !== 0) begin
                errors++;
                $display("FAIL random g%0d protocol: got rows %0d done %0d perr %0d, want %0d 1 0",
                         g, n_got, n_done, proto_err, H);
            end
            for (int p = 0; p < H; p++) begin
                exp_idx = wrap ? IW'((p + 1) % H) : IW'(p);
                exp_row = model_row(int'(exp_idx), wrap, b, s);
                checks++;
                if (got_row[p] !== exp_row || got_idx[p] !== exp_idx || got_last[p] !== (p == H - 1)) begin
                    errors++;
                    $display("FAIL random g%0d pos%0d wrap %0d: got idx %0d row %b last %b, want idx %0d row %b last %b",
                             g, p, wrap, got_idx[p], got_row[p], got_last[p], exp_idx, exp_row, p == H - 1);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] exp_row;
        for (int r = 0; r < H; r++) begin
            mg[r] = W'($urandom);
            in_rows[r] = mg[r];
        end
        run_gen(1, 1'b0, 9'h008, 9'h00C, 2, 0, 1'b0);
        checks++;
        if (n_stall !== 4 || proto_err !== 0 || n_got !== H || timeout) begin
            errors++;
            $display("FAIL backpressure: got stalls %0d perr %0d rows %0d, want 4 0 %0d", n_stall, proto_err, n_got, H);
        end
        for (int p = 0; p < H; p++) begin
            exp_row = model_row(p, 1'b0, 9'h008, 9'h00C);
            checks++;
            if (got_row[p] !== exp_row || got_idx[p] !== IW'(p)) begin
                errors++;
                $display("FAIL backpressure pos%0d: got idx %0d row %b, want idx %0d row %b",
                         p, got_idx[p], got_row[p], p, exp_row);
            end
        end
    endtask

    task automatic test_rule_change();
        logic [W-1:0] exp_row;
        logic [8:0] rules [0:1];
        rules[0] = 9'h048;
        rules[1] = 9'h008;
        for (int r = 0; r < H; r++) begin
            mg[r] = (r == 1 || r == 3) ? 5'b01110 : 5'b00000;
            in_rows[r] = mg[r];
        end
        for (int t = 0; t < 2; t++) begin
            run_gen(1, 1'b0, rules[t], 9'h00C, 0, 0, 1'b1);
            checks++;
            if (n_got !== H || timeout || got_row[2][2] !== (t == 0)) begin
                errors++;
                $display("FAIL rule t%0d centre: got rows %0d cell %b, want %0d %b", t, n_got, got_row[2][2], H, t == 0);
            end
            for (int p = 0; p < H; p++) begin
                exp_row = model_row(p, 1'b0, rules[t], 9'h00C);
                checks++;
                if (got_row[p] !== exp_row || got_idx[p] !== IW'(p)) begin
                    errors++;
                    $display("FAIL rule t%0d pos%0d: got idx %0d row %b, want idx %0d row %b",
                             t, p, got_idx[p], got_row[p], p, exp_row);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        load_blinker();
        i_wrap = 1'b0; i_birth = 9'h008; i_survive = 9'h00C;
        i_out_ready = 1'b1;
        for (int r = 0; r < 3; r++) begin
            i_row = in_rows[r];
            i_row_valid = 1'b1;
            @(posedge i_clk);
            #1;
        end
        i_row_valid = 1'b0;
        i_out_ready = 1'b0;
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        checks++;
        if (o_out_valid !== 1'b0 || o_busy !== 1'b0 || o_row_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: got valid %b busy %b ready %b, want 0 0 1", o_out_valid, o_busy, o_row_ready);
        end
        test_blinker("after_reset");
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp_row;
        load_blinker();
        for (int r = 0; r < H; r++) in_rows[H + r] = (r == 2) ? 5'b01110 : 5'b00000;
        run_gen(2, 1'b0, 9'h008, 9'h00C, 0, 0, 1'b0);
        checks++;
        if (n_got !== 2 * H || n_done !== 2 || timeout || g_cycles > 2 * (H + 3)) begin
            errors++;
            $display("FAIL back_to_back: got rows %0d done %0d cycles %0d, want %0d 2 <=%0d",
                     n_got, n_done, g_cycles, 2 * H, 2 * (H + 3));
        end
        for (int p = 0; p < 2 * H; p++) begin
            if (p < H) exp_row = ((p % H) == 2) ? 5'b01110 : 5'b00000;
            else exp_row = in_rows[p - H];
            checks++;
            if (got_row[p] !== exp_row || got_idx[p] !== IW'(p % H) || got_last[p] !== ((p % H) == H - 1)) begin
                errors++;
                $display("FAIL back_to_back pos%0d: got idx %0d row %b last %b, want idx %0d row %b last %b",
                         p, got_idx[p], got_row[p], got_last[p], p % H, exp_row, (p % H) == H - 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_blinker("blinker");
        test_full_row();
        test_backpressure();
        test_rule_change();
        test_random();
        test_mid_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
